// File: rtl/pos_uart_framer_pkg.sv
// Shared types and constants for the position-to-UART packetizer.
// Build option: define POS_FRAME_CHECKSUM_EN to append a payload checksum
// byte to every frame (11-byte frames instead of 10).
package pos_frame_pkg;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

`ifdef POS_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // One solver result: the 2-D coordinate pair carried by a frame.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } coord_t;

endpackage

// File: rtl/pos_uart_framer_if.sv
// Valid/ready byte stream between the framer (master) and the UART TX (slave).
interface pos_uart_framer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/pos_uart_framer_byte_sel.sv
// Combinational frame byte selector: maps a byte index onto the headers,
// the big-endian X/Y payload and, when POS_FRAME_CHECKSUM_EN is defined,
// the mod-256 sum of the eight payload bytes.
module pos_frame_byte_sel
  import pos_frame_pkg::*;
(
  input  coord_t     coord,
  input  idx_t       idx,
  output logic [7:0] byte_o
);

`ifdef POS_FRAME_CHECKSUM_EN
  logic [7:0] checksum;

  // Headers are deliberately excluded from the sum.
  always_comb begin
    checksum = coord.x[31:24] + coord.x[23:16] + coord.x[15:8] + coord.x[7:0]
             + coord.y[31:24] + coord.y[23:16] + coord.y[15:8] + coord.y[7:0];
  end
`endif

  // Byte mux indexed by position within the frame.
  always_comb begin
    // NOTE: a default before the case keeps unused index values from inferring a latch.
    byte_o = 8'h00;
    case (idx)
      4'd0:    byte_o = HDR0;
      4'd1:    byte_o = HDR1;
      4'd2:    byte_o = coord.x[31:24];
      4'd3:    byte_o = coord.x[23:16];
      4'd4:    byte_o = coord.x[15:8];
      4'd5:    byte_o = coord.x[7:0];
      4'd6:    byte_o = coord.y[31:24];
      4'd7:    byte_o = coord.y[23:16];
      4'd8:    byte_o = coord.y[15:8];
      4'd9:    byte_o = coord.y[7:0];
`ifdef POS_FRAME_CHECKSUM_EN
      4'd10:   byte_o = checksum;
`endif
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/pos_uart_framer.sv
// Position packetizer: captures each solver result and streams it as a
// fixed-length byte frame to the UART TX. A one-deep pending slot absorbs a
// result arriving mid-frame; later arrivals are dropped and counted.
// Build option: POS_FRAME_CHECKSUM_EN adds a trailing checksum byte.
module pos_uart_framer
  import pos_frame_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pos_valid,
  input  logic [31:0]               x_2d,
  input  logic [31:0]               y_2d,
  pos_uart_framer_if.master         tx,
  output logic                      busy,
  output logic [7:0]                drop_cnt
);

  state_e     state_q, state_d;
  idx_t       idx_q, idx_d;
  coord_t     frame_q, frame_d;
  coord_t     pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q, busy_d;

  coord_t     new_coord;
  logic       handshake;
  logic       last_byte;
  logic [7:0] sel_byte;

  assign new_coord = '{x: x_2d, y: y_2d};
  assign handshake = tx_valid_q & tx.tx_ready;
  assign last_byte = (idx_q == LAST_IDX);

  // Frame sequencing, pending-slot management and drop counting.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (pos_valid) begin
          frame_d = new_coord;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (handshake && last_byte) begin
          // Frame boundary: the only point where the frame registers reload.
          idx_d = '0;
          if (pend_valid_q) begin
            frame_d = pend_q;
            if (pos_valid) begin
              pend_d = new_coord;
            end else begin
              pend_valid_d = 1'b0;
            end
          end else if (pos_valid) begin
            frame_d = new_coord;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            idx_d = idx_q + 1'b1;
          end
          if (pos_valid) begin
            if (!pend_valid_q) begin
              pend_d       = new_coord;
              pend_valid_d = 1'b1;
            end else if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Byte for the next cycle is chosen from the next-state frame and index so
  // tx_data can be registered without adding a bubble between frames.
  pos_frame_byte_sel u_byte_sel (
    .coord  (frame_d),
    .idx    (idx_d),
    .byte_o (sel_byte)
  );

  // Registered output stage; holds the last byte once the stream goes idle.
  always_comb begin
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d == SEND);
    tx_data_d  = tx_valid_d ? sel_byte : tx_data_q;
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      drop_cnt_q   <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_pos_uart_framer.sv
// Scoreboard bench for pos_uart_framer: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares on every accepted byte and checks that
// tx_data/tx_valid hold steady through stalls.
module tb_pos_uart_framer;

`ifdef POS_FRAME_CHECKSUM_EN
  localparam int LEN = 11;
`else
  localparam int LEN = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic        pos_valid;
  logic [31:0] x_2d;
  logic [31:0] y_2d;
  logic        busy;
  logic [7:0]  drop_cnt;

  pos_uart_framer_if tx_if ();

  pos_uart_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_valid (pos_valid),
    .x_2d      (x_2d),
    .y_2d      (y_2d),
    .tx        (tx_if),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected frame for one coordinate pair; checksum bytes are hand values
  // in the directed tests and this sum reproduces them.
  task automatic push_frame(input logic [31:0] x, input logic [31:0] y);
    logic [7:0] b[8];
    logic [7:0] sum;
    b = '{x[31:24], x[23:16], x[15:8], x[7:0], y[31:24], y[23:16], y[15:8], y[7:0]};
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      sum = sum + b[i];
    end
`ifdef POS_FRAME_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic pulse(input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    pos_valid = 1'b1; x_2d = x; y_2d = y;
    @(posedge clk); #1;
    pos_valid = 1'b0;
  endtask

  // Counts contiguous tx_valid cycles of the next burst; bounded wait.
  task automatic run_until_idle(output int n);
    bit seen = 0;
    bit done = 0;
    n = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (tx_if.tx_valid) begin
        seen = 1;
        n++;
      end else if (seen) begin
        done = 1;
      end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: stall stability, then scoreboard pop on each accepted byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_if.tx_data}, {24'd0, prev_data});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_if.tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", {24'd0, tx_if.tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pos_valid = 1'b0;
    x_2d = '0;
    y_2d = '0;
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_tx_data", {24'd0, tx_if.tx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, ready tied high: HDR0 one cycle after pos_valid.
    push_frame(32'h0000_0010, 32'hFFFF_FFF0);
    pulse(32'h0000_0010, 32'hFFFF_FFF0);
    check("start_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_hdr0", {24'd0, tx_if.tx_data}, 32'hA5);
    run_until_idle(cnt);
    check("single_len", cnt, LEN);
    check("single_busy_end", {31'd0, busy}, 32'd0);
    check("single_drained", exp_q.size(), 32'd0);

    // Same frame under alternating backpressure.
    push_frame(32'h0000_0010, 32'hFFFF_FFF0);
    fork
      run_until_idle(cnt);
      begin
        pulse(32'h0000_0010, 32'hFFFF_FFF0);
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          tx_if.tx_ready = ~tx_if.tx_ready;
        end
      end
    join
    tx_if.tx_ready = 1'b1;
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Pending: second result mid-frame follows with no bubble.
    push_frame(32'h0000_0010, 32'hFFFF_FFF0);
    push_frame(32'h0000_0001, 32'h0000_0002);
    fork
      run_until_idle(cnt);
      begin
        pulse(32'h0000_0010, 32'hFFFF_FFF0);
        repeat (2) @(posedge clk);
        pulse(32'h0000_0001, 32'h0000_0002);
      end
    join
    check("pend_len", cnt, 2 * LEN);
    check("pend_drained", exp_q.size(), 32'd0);

    // Overflow: third result in one frame is dropped.
    push_frame(32'h1122_3344, 32'h5566_7788);
    push_frame(32'h0000_00AA, 32'h0000_00BB);
    fork
      run_until_idle(cnt);
      begin
        pulse(32'h1122_3344, 32'h5566_7788);
        pulse(32'h0000_00AA, 32'h0000_00BB);
        pulse(32'hDEAD_BEEF, 32'hCAFE_F00D);
      end
    join
    check("ovf_len", cnt, 2 * LEN);
    check("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    check("ovf_drained", exp_q.size(), 32'd0);

    // Saturation: 300 more drops while the frame is stalled.
    tx_if.tx_ready = 1'b0;
    push_frame(32'h0102_0304, 32'h0506_0708);
    push_frame(32'h8000_0000, 32'h7FFF_FFFF);
    pulse(32'h0102_0304, 32'h0506_0708);
    pulse(32'h8000_0000, 32'h7FFF_FFFF);
    @(posedge clk); #1;
    pos_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x_2d = i; y_2d = ~i;
      @(posedge clk); #1;
    end
    pos_valid = 1'b0;
    check("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
    tx_if.tx_ready = 1'b1;
    run_until_idle(cnt);
    check("sat_drained", exp_q.size(), 32'd0);

    // Reset mid-frame at byte 5.
    push_frame(32'h0000_0010, 32'hFFFF_FFF0);
    pulse(32'h0000_0010, 32'hFFFF_FFF0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(32'h0000_0001, 32'h0000_0002);
    pulse(32'h0000_0001, 32'h0000_0002);
    check("post_rst_hdr0", {24'd0, tx_if.tx_data}, 32'hA5);
    run_until_idle(cnt);
    check("post_rst_len", cnt, LEN);
    check("post_rst_drained", exp_q.size(), 32'd0);

    // Coincidence: new result on the final handshake with pending full.
    push_frame(32'hAAAA_0001, 32'hBBBB_0001);
    push_frame(32'hAAAA_0002, 32'hBBBB_0002);
    push_frame(32'hAAAA_0003, 32'hBBBB_0003);
    fork
      run_until_idle(cnt);
      begin
        @(posedge clk); #1;
        pos_valid = 1'b1; x_2d = 32'hAAAA_0001; y_2d = 32'hBBBB_0001;
        for (int c = 1; c <= LEN; c++) begin
          @(posedge clk); #1;
          pos_valid = 1'b0;
          if (c == 2) begin
            pos_valid = 1'b1; x_2d = 32'hAAAA_0002; y_2d = 32'hBBBB_0002;
          end
          if (c == LEN) begin
            pos_valid = 1'b1; x_2d = 32'hAAAA_0003; y_2d = 32'hBBBB_0003;
          end
        end
        @(posedge clk); #1;
        pos_valid = 1'b0;
      end
    join
    check("coin_len", cnt, 3 * LEN);
    check("coin_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("coin_drained", exp_q.size(), 32'd0);
    check("coin_busy_end", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pos_uart_framer.md
# pos_uart_framer

Packetizer between the position solver and the UART transmitter. On each solver completion pulse it captures the 2-D coordinate pair and emits it as a fixed-length byte frame (two header bytes, X and Y big-endian, optional checksum) over a valid/ready byte stream consumed by the UART TX. A one-deep pending slot absorbs one solver result arriving mid-frame; further arrivals are dropped and counted.

## Interface
- HDR0, 8'hA5, first header byte
- HDR1, 8'h5A, second header byte
- clk  in  1  system clock (20 MHz domain of the solver)
- rst_n  in  1  asynchronous active-low reset
- pos_valid  in  1  one-cycle pulse: x_2d/y_2d valid (solver done)
- x_2d  in  32  X coordinate, sampled when pos_valid=1
- y_2d  in  32  Y coordinate, sampled when pos_valid=1
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  frame in progress (state SEND)
- drop_cnt  out  8  saturating count of discarded results

## Operation
- Frame byte order: HDR0, HDR1, x[31:24], x[23:16], x[15:8], x[7:0], y[31:24], y[23:16], y[15:8], y[7:0], [checksum]. FRAME_LEN = 11 with checksum, 10 without.
- Checksum = sum mod 256 of the 8 payload bytes (headers excluded).
- Byte transfer occurs on a cycle with tx_valid=1 and tx_ready=1. tx_data stable while tx_valid=1 and tx_ready=0. tx_valid never drops mid-frame.
- States: IDLE, SEND. Byte index idx counts 0..FRAME_LEN-1.
- IDLE: pos_valid=1 -> load x/y into frame registers, idx=0, go SEND.
- SEND: handshake with idx<FRAME_LEN-1 -> idx+1. Handshake at idx=FRAME_LEN-1: pending full -> load pending into frame regs, clear pending, idx=0, stay SEND; pending empty -> IDLE.
- pos_valid in SEND: pending empty -> write pending; pending full -> discard, drop_cnt+1 (saturates at 255).
- pos_valid coincident with final handshake: pending empty -> new sample becomes next frame directly (stay SEND, idx=0). Pending full -> pending becomes next frame, new sample written into pending; no drop.
- Frame registers never change during SEND except on final handshake.

## Timing
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, drop_cnt=0, pending empty, state IDLE, idx=0.
- pos_valid at cycle N (IDLE) -> tx_valid=1, tx_data=HDR0, busy=1 at N+1.
- Back-to-back frames: final-byte handshake at cycle M -> HDR0 presented at M+1, tx_valid stays 1 (zero bubbles).
- Frame end with no pending: tx_valid=0, busy=0 at M+1.
- With tx_ready tied high: one frame = FRAME_LEN cycles.
- All outputs registered. Reset asserted mid-frame aborts immediately; partial frame is not resumed.

## Configuration
- POS_FRAME_CHECKSUM_EN defined: FRAME_LEN=11, checksum byte appended after y[7:0].
- Not defined: FRAME_LEN=10, no checksum logic synthesized; frame ends after y[7:0].

## Structure
- Package pos_frame_pkg: HDR0/HDR1 defaults, FRAME_LEN (macro-dependent), IDX width, state encoding (IDLE, SEND).
- Sub-module pos_frame_byte_sel: combinational selection of frame byte from {x, y, checksum} by idx; checksum adder lives inside it under the macro.

## Test plan
- Single frame, tx_ready=1: pos_valid, x=32'h00000010, y=32'hFFFFFFF0 -> A5 5A 00 00 00 10 FF FF FF F0 [FD], tx_valid high exactly FRAME_LEN cycles, busy then 0.
- Backpressure: tx_ready toggled 1/0 per cycle on the same frame -> identical byte sequence, tx_data stable during each stall, drop_cnt=0.
- Pending: second pos_valid (x=1,y=2) at byte 3 of first frame -> second frame follows with no bubble, payload 00 00 00 01 00 00 00 02 [03].
- Overflow: three pos_valid pulses during one frame -> first frame, then frame of 2nd sample, third dropped, drop_cnt=1; 300 drops -> drop_cnt=255.
- Coincidence: pos_valid on final handshake with pending full -> pending frame sent next, new sample sent after it, drop_cnt unchanged.
- Reset mid-frame at byte 5 -> next cycle tx_valid=0, busy=0, drop_cnt=0; next pos_valid starts fresh frame with HDR0.
